pattern_detector_param: RTL and testbench

Parametrised serial bit-pattern detector with a runtime-loadable pattern and length, selectable overlapping or non-overlapping detection, and a saturating match counter. It sits on a serial bit stream qualified by `valid`, alongside the fixed-pattern Moore detectors, and replaces them wherever the pattern or the overlap mode must change without a rebuild. Its output is a registered, Moore-style one-cycle `out` pulse per detected occurrence.

---
 rtl/pattern_det_pkg.sv | 32 +++
 rtl/pattern_shift_cmp.sv | 53 +++++
 rtl/pattern_detector_param.sv | 119 +++++++++++
 tb/tb_pattern_detector_param.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pattern_det_pkg.sv
// pattern_det_pkg
//   Shared definitions for the parametrised serial pattern detector:
//   - state_t       : controller states (UNCFG = no legal configuration held,
//                     RUN = detecting)
//   - OVERLAP / NON_OVERLAP : encodings of the cfg_overlap mode bit
//   - len_mask()    : LSB-aligned mask with the low 'len' bits set
package pattern_det_pkg;

    typedef enum logic {
        UNCFG = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam logic OVERLAP     = 1'b1;
    localparam logic NON_OVERLAP = 1'b0;

    // Widest mask len_mask() can produce; detectors compare inside this width.
    localparam int MASK_MAX_W = 32;

    // Mask with bits [len-1:0] set. Lengths at or beyond the mask width
    // saturate to all ones so the shift never overflows.
    function automatic logic [MASK_MAX_W-1:0] len_mask(input int unsigned len);
        logic [MASK_MAX_W-1:0] mask;
        if (len >= MASK_MAX_W) begin
            mask = '1;
        end else begin
            mask = (MASK_MAX_W'(1) << len) - MASK_MAX_W'(1);
        end
        return mask;
    endfunction

endpackage

// File: rtl/pattern_shift_cmp.sv
// pattern_shift_cmp
//   History shift register plus masked comparator.
//   Ports:
//     clk, rst_n : clock, synchronous active-low reset
//     shift_en   : shift 'in' into the history on this edge
//     clear      : zero the history on this edge (wins over shift_en)
//     in         : serial data bit
//     pattern    : reference pattern, bit 0 = most recent bit
//     len        : number of low bits taking part in the compare
//     hit        : combinational; the history *after* shifting in 'in'
//                  matches pattern over the low 'len' bits
//   PAT_W must satisfy 2 <= PAT_W < MASK_MAX_W.
module pattern_shift_cmp
    import pattern_det_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift_en,
    input  logic             clear,
    input  logic             in,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    output logic             hit
);

    logic [PAT_W-1:0]      history_reg;
    // History extended with the incoming bit: its low PAT_W bits are the
    // next history value, so the compare sees the beat being accepted now.
    logic [PAT_W:0]        history_ext;
    logic [MASK_MAX_W-1:0] mask_full;

    assign history_ext = {history_reg, in};
    assign mask_full   = len_mask(32'(len));

    // len never exceeds PAT_W, so the extra top bit of history_ext is
    // always masked off; it is carried only to keep the compare full-width.
    assign hit = (((MASK_MAX_W'(history_ext) ^ MASK_MAX_W'(pattern)) & mask_full)
                  == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            history_reg <= '0;
        end else if (clear) begin
            history_reg <= '0;
        end else if (shift_en) begin
            history_reg <= history_ext[PAT_W-1:0];
        end
    end

endmodule

// File: rtl/pattern_detector_param.sv
// pattern_detector_param
//   Serial bit-pattern detector with runtime-loadable pattern/length,
//   overlapping or non-overlapping detection and a saturating match counter.
//   Ports:
//     clk, rst_n   : clock, synchronous active-low reset
//     in, valid    : serial bit and its qualifier (one beat per valid cycle)
//     load         : configuration strobe for cfg_pattern/cfg_len/cfg_overlap
//     cfg_pattern  : pattern, bit [cfg_len-1] received first, bit 0 last
//     cfg_len      : active length, legal 1..PAT_W
//     cfg_overlap  : 1 = overlapping, 0 = non-overlapping
//     out          : registered one-cycle pulse per match
//     match_count  : saturating match count since reset / accepted load
//     cfg_err      : registered one-cycle pulse for a rejected load
//     armed        : a legal configuration is held (state RUN)
module pattern_detector_param
    import pattern_det_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int LEN_W = $clog2(PAT_W + 1),
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in,
    input  logic             valid,
    input  logic             load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    output logic             out,
    output logic [CNT_W-1:0] match_count,
    output logic             cfg_err,
    output logic             armed
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_reg;
    logic [PAT_W-1:0] pattern_reg;
    logic [LEN_W-1:0] len_reg;
    logic             overlap_reg;
    logic [LEN_W-1:0] fill_reg;
    logic [LEN_W-1:0] fill_next;
    logic [CNT_W-1:0] count_reg;
    logic             out_reg;
    logic             cfg_err_reg;

    logic load_legal;
    logic beat;
    logic hit;
    logic match;

    assign load_legal = (cfg_len != '0) && (cfg_len <= LEN_MAX);
    // A load in the same cycle swallows the beat, whether or not it is legal.
    assign beat       = valid && !load && (state_reg == RUN);
    assign fill_next  = (fill_reg == LEN_MAX) ? fill_reg : fill_reg + LEN_W'(1);
    assign match      = beat && hit && (fill_next >= len_reg);

    pattern_shift_cmp #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_shift_cmp (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (beat),
        .clear    (load && load_legal),
        .in       (in),
        .pattern  (pattern_reg),
        .len      (len_reg),
        .hit      (hit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= UNCFG;
            pattern_reg <= '0;
            len_reg     <= '0;
            overlap_reg <= NON_OVERLAP;
            fill_reg    <= '0;
            count_reg   <= '0;
            out_reg     <= 1'b0;
            cfg_err_reg <= 1'b0;
        end else begin
            out_reg     <= 1'b0;
            cfg_err_reg <= 1'b0;
            if (load) begin
                if (load_legal) begin
                    state_reg   <= RUN;
                    pattern_reg <= cfg_pattern;
                    len_reg     <= cfg_len;
                    overlap_reg <= cfg_overlap;
                    fill_reg    <= '0;
                    count_reg   <= '0;
                end else begin
                    cfg_err_reg <= 1'b1;
                end
            end else if (beat) begin
                out_reg <= match;
                // Non-overlapping: forget the bits of the occurrence just
                // reported so the next one must be built from fresh beats.
                if (match && (overlap_reg == NON_OVERLAP)) begin
                    fill_reg <= '0;
                end else begin
                    fill_reg <= fill_next;
                end
                if (match && (count_reg != CNT_MAX)) begin
                    count_reg <= count_reg + CNT_W'(1);
                end
            end
        end
    end

    assign out         = out_reg;
    assign match_count = count_reg;
    assign cfg_err     = cfg_err_reg;
    assign armed       = (state_reg == RUN);

endmodule

// File: tb/tb_pattern_detector_param.sv
module tb_pattern_detector_param;

    localparam int PAT_W = 8;
    localparam int LEN_W = $clog2(PAT_W + 1);
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in = 1'b0;
    logic             valid = 1'b0;
    logic             load = 1'b0;
    logic [PAT_W-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic             cfg_overlap = 1'b0;
    logic             out;
    logic [CNT_W-1:0] match_count;
    logic             cfg_err;
    logic             armed;

    pattern_detector_param #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in          (in),
        .valid       (valid),
        .load        (load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .out         (out),
        .match_count (match_count),
        .cfg_err     (cfg_err),
        .armed       (armed)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            tag;
        logic             rst_n;
        logic             load;
        logic             valid;
        logic             bit_in;
        logic [PAT_W-1:0] pat;
        logic [LEN_W-1:0] len;
        logic             ovl;
        logic             exp_out;
        logic [CNT_W-1:0] exp_cnt;
        logic             exp_err;
        logic             exp_armed;
    } vec_t;

    vec_t  tbl[$];
    vec_t  exp_q[$];
    string cur_tag = "";
    int    n_vec = 0;
    int    n_bad = 0;

    function automatic vec_t mk(logic r, logic ld, logic v, logic b,
                                logic [PAT_W-1:0] p, logic [LEN_W-1:0] l, logic o,
                                logic eo, logic [CNT_W-1:0] ec, logic ee, logic ea);
        vec_t t;
        t.tag = cur_tag; t.rst_n = r; t.load = ld; t.valid = v; t.bit_in = b;
        t.pat = p; t.len = l; t.ovl = o;
        t.exp_out = eo; t.exp_cnt = ec; t.exp_err = ee; t.exp_armed = ea;
        return t;
    endfunction

    function automatic void add_rst();
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0));
    endfunction

    function automatic void add_beat(logic b, logic eo, logic [CNT_W-1:0] ec, logic ea = 1'b1);
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, b, '0, '0, 1'b0, eo, ec, 1'b0, ea));
    endfunction

    function automatic void add_idle(logic [CNT_W-1:0] ec, logic ea = 1'b1);
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, ec, 1'b0, ea));
    endfunction

    function automatic void add_load(logic [PAT_W-1:0] p, logic [LEN_W-1:0] l, logic o,
                                     logic v, logic b, logic [CNT_W-1:0] ec, logic ee);
        tbl.push_back(mk(1'b1, 1'b1, v, b, p, l, o, 1'b0, ec, ee, 1'b1));
    endfunction

    // Apply one vector: drive on the falling edge, queue its expectation,
    // check after the rising edge that consumes it.
    task automatic apply(input vec_t t);
        vec_t e;
        @(negedge clk);
        rst_n = t.rst_n; load = t.load; valid = t.valid; in = t.bit_in;
        cfg_pattern = t.pat; cfg_len = t.len; cfg_overlap = t.ovl;
        exp_q.push_back(t);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        n_vec++;
        $display("vec %0d [%s] rst_n=%0b ld=%0b v=%0b in=%0b -> out=%0b cnt=%0d err=%0b armed=%0b",
                 n_vec, e.tag, e.rst_n, e.load, e.valid, e.bit_in, out, match_count, cfg_err, armed);
        if (out !== e.exp_out || match_count !== e.exp_cnt ||
            cfg_err !== e.exp_err || armed !== e.exp_armed) begin
            n_bad++;
            $display("FAIL vec %0d %s: got out=%0b cnt=%0d err=%0b armed=%0b, required out=%0b cnt=%0d err=%0b armed=%0b",
                     n_vec, e.tag, out, match_count, cfg_err, armed,
                     e.exp_out, e.exp_cnt, e.exp_err, e.exp_armed);
        end
    endtask

    initial begin
        logic [7:0] s_bits;
        logic [7:0] s_ovl_out;
        logic [7:0] s_non_out;

        // Stream 10010010 (index 0 first); expected out per beat.
        s_bits    = 8'b0100_1001;
        s_ovl_out = 8'b1001_0000;
        s_non_out = 8'b0001_0000;

        cur_tag = "reset";
        add_rst();
        cur_tag = "uncfg_ignore";
        add_beat(1, 0, 0, 0); add_beat(0, 0, 0, 0); add_beat(0, 0, 0, 0);
        add_beat(1, 0, 0, 0); add_beat(0, 0, 0, 0);

        cur_tag = "overlap";
        add_load(8'b0001_0010, 5, 1'b1, 0, 0, 0, 0);
        begin
            int c = 0;
            for (int i = 0; i < 8; i++) begin
                if (s_ovl_out[i]) c++;
                add_beat(s_bits[i], s_ovl_out[i], CNT_W'(c));
            end
        end
        add_idle(2);

        cur_tag = "non_overlap";
        add_load(8'b0001_0010, 5, 1'b0, 0, 0, 0, 0);
        begin
            int c = 0;
            for (int i = 0; i < 8; i++) begin
                if (s_non_out[i]) c++;
                add_beat(s_bits[i], s_non_out[i], CNT_W'(c));
            end
        end
        add_idle(1);

        cur_tag = "valid_gaps";
        add_load(8'b0001_0010, 5, 1'b0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            add_beat(s_bits[i], 0, 0);
            add_idle(0); add_idle(0); add_idle(0);
        end
        add_beat(0, 1, 1);
        add_idle(1);

        cur_tag = "illegal_len0";
        add_load(8'hFF, 0, 1'b1, 0, 0, 1, 1);
        add_idle(1);
        cur_tag = "illegal_len9_with_beat";
        add_load(8'hFF, 9, 1'b1, 1, 1, 1, 1);
        cur_tag = "old_cfg_still_detects";
        add_beat(0, 0, 1); add_beat(0, 0, 1); add_beat(1, 0, 1); add_beat(0, 0, 1);
        add_beat(1, 0, 1); add_beat(0, 0, 1); add_beat(0, 0, 1); add_beat(1, 0, 1);
        add_beat(0, 1, 2);
        add_idle(2);

        cur_tag = "legal_load_with_beat";
        add_load(8'b0001_0010, 5, 1'b1, 1, 1, 0, 0);
        add_beat(0, 0, 0); add_beat(0, 0, 0); add_beat(1, 0, 0); add_beat(0, 0, 0);
        add_beat(0, 0, 0); add_beat(1, 0, 0); add_beat(0, 1, 1);

        cur_tag = "len1_saturate";
        add_load(8'b0000_0001, 1, 1'b1, 0, 0, 0, 0);
        for (int i = 1; i <= 7; i++) add_beat(1, 1, CNT_W'((i > 3) ? 3 : i));
        add_idle(3);
        add_beat(0, 0, 3);

        cur_tag = "reset_mid_stream";
        add_load(8'b0001_0010, 5, 1'b1, 0, 0, 0, 0);
        add_beat(1, 0, 0); add_beat(0, 0, 0); add_beat(0, 0, 0); add_beat(1, 0, 0);
        add_rst();
        for (int i = 0; i < 5; i++) add_beat(s_bits[i], 0, 0, 0);
        add_load(8'b0001_0010, 5, 1'b1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) add_beat(s_bits[i], (i == 4), CNT_W'((i == 4) ? 1 : 0));

        cur_tag = "len8_full_width";
        add_load(8'b1011_0011, 8, 1'b0, 0, 0, 0, 0);
        s_bits = 8'b1100_1101;      // 1,0,1,1,0,0,1,1 index 0 first
        for (int i = 0; i < 8; i++) add_beat(s_bits[i], (i == 7), CNT_W'((i == 7) ? 1 : 0));
        for (int i = 0; i < 7; i++) add_beat(s_bits[i], 0, 1);

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
